// File: rtl/exins_responder.sv
// Memory-side responder for the external instruction-fetch port:
// preloadable word store feeding a fixed-latency, flushable response pipe.
module exins_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           exIns_ren,
  input  logic [31:0]                    exIns_addr,
  input  logic                           flush,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data,
  output logic                           exIns_valid,
  output logic [31:0]                    exIns_in,
  output logic                           err,
  output logic [15:0]                    req_cnt
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] rd_idx;
  logic          oor;
  logic          mis;
  logic [31:0]   rd_word;

  logic [LATENCY-1:0] v_q;
  logic [LATENCY-1:0] v_d;
  logic [31:0]        d_q [LATENCY];
  logic [31:0]        d_d [LATENCY];

  logic        err_q;
  logic        err_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Store is not reset; a same-edge preload is invisible to the read.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  assign rd_idx  = exIns_addr[AW+1:2];
  assign oor     = |exIns_addr[31:AW+2];
  assign mis     = |exIns_addr[1:0];
  assign rd_word = oor ? NOP_WORD : mem_q[rd_idx];

  // Data only moves with a live valid so the output holds when idle.
  always_comb begin
    v_d    = '0;
    d_d    = d_q;
    v_d[0] = exIns_ren;
    if (exIns_ren) begin
      d_d[0] = rd_word;
    end
    for (int i = 1; i < LATENCY; i++) begin
      v_d[i] = v_q[i-1] & ~flush;
      if (v_d[i]) begin
        d_d[i] = d_q[i-1];
      end
    end
  end

  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (exIns_ren) begin
      err_d = err_q | oor | mis;
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      v_q   <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign exIns_valid = v_q[LATENCY-1];
  assign exIns_in    = d_q[LATENCY-1];
  assign err         = err_q;
  assign req_cnt     = cnt_q;

endmodule
